// File: rtl/clm_sched_pkg.sv
// Shared types and helpers for the CLM AES job scheduler.
//   red_poly_t    : one byte of mask randomness
//   p_det_t       : 5-bit p_det selector for the core
//   sched_state_t : scheduler FSM states
//   rnd_accept()  : rejection rule applied to each RNG byte
package clm_sched_pkg;

  typedef logic [7:0] red_poly_t;
  typedef logic [4:0] p_det_t;

  localparam int NUM_VECT = 23;

  typedef enum logic [2:0] {
    S_IDLE, S_DRAW_P, S_DRAW_V, S_START, S_WAIT, S_RESP
  } sched_state_t;

  // draw_p=1: byte feeds p_det, low five bits must lie in 1..p_max.
  // draw_p=0: byte feeds a mask entry, must be nonzero so the mask is invertible.
  function automatic logic rnd_accept(input logic draw_p, input logic [7:0] b,
                                      input int unsigned p_max);
    if (draw_p) return (b[4:0] != 5'd0) && ({27'd0, b[4:0]} <= p_max);
    return b != 8'd0;
  endfunction

endpackage

// File: rtl/clm_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above ptr
// (wrapping modulo NUM_REQ).
//   req   : request vector
//   ptr   : search start index
//   grant : one-hot winner (zero when no request)
//   idx   : encoded winner
//   any   : at least one request present
module clm_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [IW-1:0] c;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = IW'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = c;
      end
    end
  end

endmodule

// File: rtl/clm_job_scheduler.sv
// Shares one CLM AES core between NUM_REQ requesters. Per job: arbitrate,
// draw p_det and 23 mask bytes from the RNG stream (with rejection), pulse
// the core start, wait for completion or timeout, return the tagged result.
//   req_*   : requester side (valid/ready, plaintext, key)
//   rnd_*   : byte-wide RNG stream
//   core_*  : CLM AES core operands, start pulse and completion
//   rsp_*   : response (id, ciphertext, timeout error)
//   busy    : a job is in flight
module clm_job_scheduler
  import clm_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int P_MAX   = 15,
  parameter int TIMEOUT = 1023
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][127:0]         req_plaintext,
  input  logic [NUM_REQ-1:0][127:0]         req_key,
  input  logic                              rnd_valid,
  output logic                              rnd_ready,
  input  logic [7:0]                        rnd_data,
  output logic                              core_drdy_i,
  output logic [127:0]                      core_plaintext,
  output logic [127:0]                      core_key,
  output red_poly_t [0:NUM_VECT-1]          core_random_vect,
  output p_det_t                            core_p_det,
  input  logic                              core_drdy_o,
  input  logic [127:0]                      core_ciphertext,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
  output logic [127:0]                      rsp_ciphertext,
  output logic                              rsp_err,
  output logic                              busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_t  state, state_nxt;
  logic [IW-1:0] ptr, cur_id, win;
  logic [NUM_REQ-1:0] grant;
  logic          any;
  logic [4:0]    vidx;
  logic [TW-1:0] tcnt;
  logic          drdy_q;
  logic          rnd_take, p_ok, v_ok, drdy_edge, tmo;

  clm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  // req_ready is gated by rst so every output reads zero while reset is held.
  assign req_ready   = (state == S_IDLE && rst) ? grant : '0;
  assign rnd_ready   = (state == S_DRAW_P) || (state == S_DRAW_V);
  assign core_drdy_i = (state == S_START);
  assign rsp_valid   = (state == S_RESP);
  assign busy        = (state != S_IDLE);

  assign rnd_take  = rnd_valid && rnd_ready;
  assign p_ok      = rnd_take && rnd_accept(1'b1, rnd_data, P_MAX);
  assign v_ok      = rnd_take && rnd_accept(1'b0, rnd_data, P_MAX);
  // Only a 0->1 transition counts; a level already high entering WAIT is ignored.
  assign drdy_edge = core_drdy_o && !drdy_q;
  assign tmo       = (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (any) state_nxt = S_DRAW_P;
      S_DRAW_P: if (p_ok) state_nxt = S_DRAW_V;
      S_DRAW_V: if (v_ok && vidx == 5'(NUM_VECT - 1)) state_nxt = S_START;
      S_START:  state_nxt = S_WAIT;
      S_WAIT:   if (drdy_edge || tmo) state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr              <= '0;
      cur_id           <= '0;
      vidx             <= '0;
      tcnt             <= '0;
      drdy_q           <= 1'b0;
      core_plaintext   <= '0;
      core_key         <= '0;
      core_random_vect <= '0;
      core_p_det       <= '0;
      rsp_id           <= '0;
      rsp_ciphertext   <= '0;
      rsp_err          <= 1'b0;
    end else begin
      drdy_q <= core_drdy_o;
      case (state)
        S_IDLE: if (any) begin
          core_plaintext <= req_plaintext[win];
          core_key       <= req_key[win];
          cur_id         <= win;
          ptr            <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          vidx           <= '0;
        end
        S_DRAW_P: if (p_ok) core_p_det <= rnd_data[4:0];
        S_DRAW_V: if (v_ok) begin
          core_random_vect[vidx] <= rnd_data;
          vidx <= (vidx == 5'(NUM_VECT - 1)) ? '0 : vidx + 1'b1;
        end
        S_START: tcnt <= '0;
        S_WAIT: begin
          if (drdy_edge || tmo) begin
            rsp_id         <= cur_id;
            rsp_ciphertext <= drdy_edge ? core_ciphertext : '0;
            rsp_err        <= !drdy_edge;
            tcnt           <= '0;
            // Scrub secrets as soon as the core is done with them.
            core_plaintext   <= '0;
            core_key         <= '0;
            core_random_vect <= '0;
            core_p_det       <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RESP: if (rsp_ready) begin
          rsp_ciphertext <= '0;
          rsp_err        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clm_job_scheduler.sv
// Scoreboard bench for clm_job_scheduler: requester/RNG/core/response
// environment driven on the falling edge, checked 2 ns later.
module tb_clm_job_scheduler;
  import clm_sched_pkg::*;

  localparam int NR = 4, PM = 15, TO = 20, LAT = 5, IW = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic [NR-1:0] req_valid = '0, req_ready;
  logic [NR-1:0][127:0] req_plaintext, req_key;
  logic rnd_valid = 1'b0, rnd_ready;
  logic [7:0] rnd_data = '0;
  logic core_drdy_i, core_drdy_o = 1'b0;
  logic [127:0] core_plaintext, core_key, core_ciphertext = '0;
  red_poly_t [0:NUM_VECT-1] core_random_vect;
  p_det_t core_p_det;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
  logic [IW-1:0] rsp_id;
  logic [127:0] rsp_ciphertext;

  always #5 clk = ~clk;

  clm_job_scheduler #(.NUM_REQ(NR), .P_MAX(PM), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_plaintext(req_plaintext), .req_key(req_key), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .rnd_data(rnd_data), .core_drdy_i(core_drdy_i),
    .core_plaintext(core_plaintext), .core_key(core_key),
    .core_random_vect(core_random_vect), .core_p_det(core_p_det),
    .core_drdy_o(core_drdy_o), .core_ciphertext(core_ciphertext),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_ciphertext(rsp_ciphertext), .rsp_err(rsp_err), .busy(busy));

  typedef struct { int id; logic [127:0] pt, key; int p, m, extra; bit dead; } job_t;
  typedef struct { int p, m, extra; } pm_t;

  job_t sb[$];
  pm_t  pmq[$];
  logic [7:0] rngq[$];
  int   grant_log[$];
  logic [127:0] pt_a[NR], key_a[NR];
  int   req_add[NR], req_done[NR];
  int   bp_len = 0;
  bit   core_dead = 0;
  int   tests = 0, fails = 0;
  int   cyc = 0, mptr = 0, rv_cnt = 0, acc_cyc = 0, ccnt = 0, pulses = 0, resp_cnt = 0;
  bit   after_hs = 0, stable_ok = 1;
  logic [255:0] snap;
  logic [127:0] cur_ct;

  for (genvar g = 0; g < NR; g++) begin : g_req
    assign req_plaintext[g] = pt_a[g];
    assign req_key[g]       = key_a[g];
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stand-in cipher: the scheduler only forwards it, any bijection will do.
  function automatic logic [127:0] ct_model(input logic [127:0] pt, input logic [127:0] key);
    return pt ^ {key[63:0], key[127:64]} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  endfunction

  // Queue one job's worth of RNG bytes; rej adds two bad p bytes and one zero mask.
  task automatic push_job(input logic [7:0] pbyte, input logic [7:0] m, input bit rej);
    pm_t e;
    if (rej) begin rngq.push_back(8'h00); rngq.push_back(8'h10); end
    rngq.push_back(pbyte);
    if (rej) rngq.push_back(8'h00);
    for (int k = 0; k < NUM_VECT; k++) rngq.push_back(m);
    e.p = int'(pbyte[4:0]); e.m = int'(m); e.extra = rej ? 3 : 0;
    pmq.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk); #3;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    bit pend = 1;
    while (pend && n < budget) begin
      pend = busy || sb.size() > 0;
      for (int k = 0; k < NR; k++) if (req_add[k] > req_done[k]) pend = 1;
      tick(); n++;
    end
    tick();
    if (n >= budget) chk("wait_budget", 256'(n), 256'(0));
  endtask

  // Environment: drive at the falling edge, observe 2 ns later.
  always @(negedge clk) begin
    int w;
    logic [NR-1:0] oh;
    logic [183:0] ev;
    cyc++;
    rnd_valid = rngq.size() > 0;
    rnd_data  = rnd_valid ? rngq[0] : 8'h00;
    for (int k = 0; k < NR; k++) req_valid[k] = req_add[k] > req_done[k];
    rsp_ready = rsp_valid && (rv_cnt >= bp_len);
    if (ccnt > 0) begin
      ccnt--;
      if (ccnt == 0) begin core_drdy_o = 1'b1; core_ciphertext = cur_ct; end
    end
    #2;
    if (!rst) begin
      mptr = 0; rv_cnt = 0; ccnt = 0; after_hs = 0;
    end else begin
      if (after_hs) begin chk("busy_after_rsp", 256'(busy), 256'(0)); after_hs = 0; end
      if (!busy && |req_valid) begin
        w = -1;
        for (int k = 0; k < NR; k++) begin
          int c;
          c = (mptr + k) % NR;
          if (w < 0 && req_valid[c]) w = c;
        end
        oh = '0; oh[w] = 1'b1;
        chk("req_ready", 256'(req_ready), 256'(oh));
        begin
          job_t j;
          pm_t e;
          e = '{p: 0, m: 0, extra: 0};
          if (pmq.size() > 0) e = pmq.pop_front();
          j.id = w; j.pt = pt_a[w]; j.key = key_a[w];
          j.p = e.p; j.m = e.m; j.extra = e.extra; j.dead = core_dead;
          sb.push_back(j);
        end
        req_done[w]++;
        mptr = (w + 1) % NR;
        acc_cyc = cyc;
        grant_log.push_back(w);
      end
      if (rnd_valid && rnd_ready) void'(rngq.pop_front());
      if (core_drdy_i) begin
        pulses++;
        if (sb.size() > 0) begin
          for (int k = 0; k < NUM_VECT; k++) ev[k*8 +: 8] = 8'(sb[0].m);
          chk("core_p_det", 256'(core_p_det), 256'(sb[0].p));
          chk("core_vect", 256'(core_random_vect), 256'(ev));
          chk("core_pt", 256'(core_plaintext), 256'(sb[0].pt));
          chk("core_key", 256'(core_key), 256'(sb[0].key));
        end
        if (!core_dead) begin
          core_drdy_o = 1'b0; ccnt = LAT;
          cur_ct = ct_model(core_plaintext, core_key);
        end
      end
      if (rsp_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", 256'(rsp_valid), 256'(0));
        else begin
          if (rv_cnt == 0) begin
            chk("latency", 256'(cyc - acc_cyc),
                256'(sb[0].dead ? 26 + TO : 26 + LAT + sb[0].extra));
            snap = 256'({rsp_err, rsp_id, rsp_ciphertext});
            stable_ok = 1;
          end else if (snap != 256'({rsp_err, rsp_id, rsp_ciphertext})) stable_ok = 0;
          if (rsp_ready) begin
            chk("rsp_id", 256'(rsp_id), 256'(sb[0].id));
            chk("rsp_ct", 256'(rsp_ciphertext),
                256'(sb[0].dead ? 128'd0 : ct_model(sb[0].pt, sb[0].key)));
            chk("rsp_err", 256'(rsp_err), 256'(sb[0].dead));
            if (rv_cnt > 0) chk("rsp_stable", 256'(stable_ok), 256'(1));
            void'(sb.pop_front());
            rv_cnt = 0; after_hs = 1; resp_cnt++;
          end else rv_cnt++;
        end
      end
    end
  end

  initial begin
    int gl0, n;
    int fair_exp[5];
    fair_exp = '{0, 1, 2, 3, 0};
    for (int k = 0; k < NR; k++) begin
      pt_a[k] = '0; key_a[k] = '0; req_add[k] = 0; req_done[k] = 0;
    end
    tick(); tick();
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_outs", 256'({rsp_valid, core_drdy_i, rnd_ready, req_ready, rsp_err, rsp_id}), 256'(0));
    chk("rst_vect", 256'({core_p_det, core_random_vect}), 256'(0));
    chk("rst_data", 256'({core_plaintext, rsp_ciphertext}), 256'(0));
    rst = 1'b1;
    tick();

    // single job from requester 2
    pt_a[2] = 128'hff; key_a[2] = '0;
    push_job(8'd15, 8'd109, 0);
    req_add[2]++;
    wait_done(200);

    // rejection: 00,10 rejected for p, 00 rejected for masks
    pt_a[3] = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff; key_a[3] = 128'h1234;
    push_job(8'h05, 8'h6d, 1);
    req_add[3]++;
    wait_done(200);

    // fairness: all four requesters pending at once, requester 0 twice
    for (int k = 0; k < NR; k++) begin
      pt_a[k]  = {$urandom, $urandom, $urandom, $urandom};
      key_a[k] = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int j = 0; j < 5; j++) push_job(8'hE0 | 8'(j + 1), 8'(8'h30 + j), 0);
    gl0 = grant_log.size();
    req_add[0] += 2; req_add[1]++; req_add[2]++; req_add[3]++;
    wait_done(600);
    for (int k = 0; k < 5; k++)
      chk("fair_order", 256'(gl0 + k < grant_log.size() ? grant_log[gl0 + k] : -1),
          256'(fair_exp[k]));

    // timeout with drdy_o stuck high, plus response backpressure
    core_dead = 1; bp_len = 10;
    push_job(8'd7, 8'h99, 0);
    req_add[1]++;
    wait_done(300);
    core_dead = 0; bp_len = 0;

    // reset mid DRAW_V at vidx=10
    pt_a[2] = 128'hdead_beef;
    push_job(8'd9, 8'h77, 0);
    req_add[2]++;
    n = 0;
    while (!rnd_ready && n < 50) begin tick(); n++; end
    chk("reached_draw", 256'(rnd_ready), 256'(1));
    repeat (11) tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_outs", 256'({rsp_valid, core_drdy_i, rnd_ready, req_ready}), 256'(0));
    chk("mid_rst_vect", 256'({core_p_det, core_random_vect}), 256'(0));
    chk("mid_rst_data", 256'({core_plaintext, core_key}), 256'(0));
    rngq.delete(); sb.delete(); pmq.delete();
    tick(); tick();
    rst = 1'b1;
    tick();

    // ptr must be back at 0: requesters 1 and 3 pending -> 1 first, then 3
    pt_a[1] = 128'h1111; pt_a[3] = 128'h3333;
    push_job(8'd2, 8'h41, 0);
    push_job(8'd3, 8'h42, 0);
    gl0 = grant_log.size();
    req_add[1]++; req_add[3]++;
    wait_done(300);
    chk("post_rst_g0", 256'(gl0 < grant_log.size() ? grant_log[gl0] : -1), 256'(1));
    chk("post_rst_g1", 256'(gl0 + 1 < grant_log.size() ? grant_log[gl0 + 1] : -1), 256'(3));

    chk("drdy_pulses", 256'(pulses), 256'(10));
    chk("responses", 256'(resp_cnt), 256'(10));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
